route_judge: RTL

Per-router arbitration stage that sits directly upstream of the fail-masking stage. Each cycle it samples the routed direction of the packet at each of the three input channels (X, Y, LOCAL). It resolves contention for each output port with a round-robin pointer and applies downstream backpressure. It registers a per-channel fail vector one cycle later, which the fail-masking stage uses to clear unsent directions. It also tracks consecutive failures per channel and pulses a drop flag when a channel is starved.

---
 rtl/route_judge.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/route_judge.sv
// ---------------------------------------------------------------------------
// route_judge
//   Per-router arbitration stage. Each cycle it samples the routed direction
//   of the X, Y and LOCAL input channels, arbitrates every output port with
//   its own round-robin pointer, applies downstream backpressure, and
//   registers a per-channel fail vector that the downstream fail-masking
//   stage uses to clear unsent directions. A per-channel retry counter
//   pulses drop when a channel has failed MAX_RETRY times in a row.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   enable      in   stage enable; 0 holds all state and outputs
//   dout_x      in   [1:0] X channel direction (00 NONE,01 X,10 Y,11 LOCAL)
//   dout_y      in   [1:0] Y channel direction
//   dout_local  in   [1:0] LOCAL channel direction
//   port_ready  in   [2:0] downstream ready: [2] X, [1] Y, [0] LOCAL out
//   fail        out  [2:0] registered fail: [2] X, [1] Y, [0] LOCAL channel
//   sel_x       out  [1:0] source granted X out (00 none,01 X,10 Y,11 LOCAL)
//   sel_y       out  [1:0] source granted Y out
//   sel_local   out  [1:0] source granted LOCAL out
//   drop        out  [2:0] one-cycle starvation pulse, bit order as fail
// ---------------------------------------------------------------------------
module route_judge #(
    parameter int MAX_RETRY = 7,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] dout_x,
    input  logic [1:0] dout_y,
    input  logic [1:0] dout_local,
    input  logic [2:0] port_ready,
    output logic [2:0] fail,
    output logic [1:0] sel_x,
    output logic [1:0] sel_y,
    output logic [1:0] sel_local,
    output logic [2:0] drop
);

    // Internally channels and output ports share one index: 0 X, 1 Y, 2 LOCAL.
    // The wire code of index i is i+1.
    localparam logic [1:0]     CH_X   = 2'd0;
    localparam logic [CNT_W:0] LP_MAX = (CNT_W+1)'(MAX_RETRY);

    function automatic logic [1:0] next_ch(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    logic [1:0]     w_dout      [3];
    logic [2:0]     w_ready;
    logic           w_win_valid [3];
    logic [1:0]     w_win_ch    [3];
    logic [1:0]     w_ptr_nxt   [3];
    logic [1:0]     w_sel_nxt   [3];
    logic [2:0]     w_grant;
    logic [2:0]     w_fail_ch;
    logic [2:0]     w_drop_ch;
    logic [CNT_W:0] w_inc       [3];
    logic [CNT_W-1:0] w_cnt_nxt [3];

    logic [1:0]       r_ptr [3];
    logic [1:0]       r_sel [3];
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_fail_ch;
    logic [2:0]       r_drop_ch;

    assign w_dout[0] = dout_x;
    assign w_dout[1] = dout_y;
    assign w_dout[2] = dout_local;
    // port_ready is MSB-first (X at bit 2); flip it to the internal index.
    assign w_ready   = {port_ready[0], port_ready[1], port_ready[2]};

    // Round-robin scan per output port, starting at the port's pointer.
    always_comb begin : arbitrate
        logic [1:0] v_cand;
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value unassigned and no latch is inferred.
        w_grant = '0;
        v_cand  = CH_X;
        for (int p = 0; p < 3; p++) begin
            w_win_valid[p] = 1'b0;
            w_win_ch[p]    = CH_X;
            w_ptr_nxt[p]   = r_ptr[p];
            w_sel_nxt[p]   = 2'b00;
            v_cand         = r_ptr[p];
            for (int k = 0; k < 3; k++) begin
                if (!w_win_valid[p] && w_ready[p] && (w_dout[v_cand] == 2'(p + 1))) begin
                    w_win_valid[p] = 1'b1;
                    w_win_ch[p]    = v_cand;
                end
                v_cand = next_ch(v_cand);
            end
            if (w_win_valid[p]) begin
                w_ptr_nxt[p]        = next_ch(w_win_ch[p]);
                w_sel_nxt[p]        = w_win_ch[p] + 2'd1;
                w_grant[w_win_ch[p]] = 1'b1;
            end
        end
    end

    // A requesting channel that was not granted has failed, whether it lost
    // contention or its port was back-pressured.
    always_comb begin : retry
        for (int c = 0; c < 3; c++) begin
            w_fail_ch[c] = (w_dout[c] != 2'b00) && !w_grant[c];
            w_inc[c]     = {1'b0, r_cnt[c]} + 1'b1;
            w_drop_ch[c] = 1'b0;
            w_cnt_nxt[c] = '0;
            if (w_fail_ch[c]) begin
                if (w_inc[c] == LP_MAX) begin
                    w_drop_ch[c] = 1'b1;
                end else begin
                    w_cnt_nxt[c] = w_inc[c][CNT_W-1:0];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_ptr[i] <= CH_X;
                r_sel[i] <= 2'b00;
                r_cnt[i] <= '0;
            end
            r_fail_ch <= '0;
            r_drop_ch <= '0;
        end else if (enable) begin
            for (int i = 0; i < 3; i++) begin
                r_ptr[i] <= w_ptr_nxt[i];
                r_sel[i] <= w_sel_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_fail_ch <= w_fail_ch;
            r_drop_ch <= w_drop_ch;
        end
    end

    assign sel_x     = r_sel[0];
    assign sel_y     = r_sel[1];
    assign sel_local = r_sel[2];
    assign fail      = {r_fail_ch[0], r_fail_ch[1], r_fail_ch[2]};
    assign drop      = {r_drop_ch[0], r_drop_ch[1], r_drop_ch[2]};

endmodule
